key_event_classifier: RTL and testbench
=======================================

// Module: key_event_classifier
// PURPOSE
//   Classifies debounced key pulses into short-press, long-press and double-click events.
//   Sits directly downstream of the key debouncer.
//   Consumes its one-cycle press_down/press_up pulses and emits one-cycle event pulses
//   to the UI/control logic. Optional auto-repeat while a long press is held.
// PARAMETERS
//   LONG_CYC    50_000_000  hold time (clk cycles) before long_press fires (1 s @ 50 MHz)
//   DCLK_CYC    12_500_000  max release gap (cycles) for the second click of a double click
//   REPEAT_CYC  5_000_000   auto-repeat period (cycles) in LONG; used only with macro
//   CNT_W       26          counter width; 2**CNT_W > max(LONG_CYC,DCLK_CYC,REPEAT_CYC)
// PORTS
//   clk           in   1  clock
//   rst_n         in   1  reset, asynchronous, active-low
//   press_down    in   1  one-cycle pulse: debounced key pressed
//   press_up      in   1  one-cycle pulse: debounced key released
//   short_press   out  1  one-cycle pulse: single short click recognised
//   long_press    out  1  one-cycle pulse: hold reached LONG_CYC
//   double_click  out  1  one-cycle pulse: two clicks within DCLK_CYC gap
//   repeat_pulse  out  1  one-cycle pulse every REPEAT_CYC in LONG (0 without macro)
//   key_held      out  1  level: high while state is HELD1, HELD2 or LONG
// BEHAVIOUR
//   - All outputs registered. Reset: state=IDLE, cnt=0, every output 0.
//   - Event latency: pulse is high in the cycle after the triggering input or timeout.
//   - Single counter cnt: cleared to 0 on every state change; +1 per cycle otherwise.
//     "Timeout N" means cnt==N-1 in the current state.
//   - FSM:
//     IDLE : press_down -> HELD1
//     HELD1: press_up -> GAP; timeout LONG_CYC -> LONG, long_press
//     GAP  : press_down -> HELD2; timeout DCLK_CYC -> IDLE, short_press
//     HELD2: press_up -> IDLE, double_click;
//            timeout LONG_CYC -> LONG, short_press AND long_press in same cycle
//     LONG : press_up -> IDLE
//   - Input beats timeout: an input pulse in the timeout cycle takes its transition.
//     In GAP, press_down at cnt==DCLK_CYC-1 still counts as the second click.
//   - press_down and press_up high together: press_down ignored, press_up acts per state.
//   - Unexpected pulses are ignored, no state change:
//     press_up in IDLE or GAP; press_down in HELD1, HELD2 or LONG.
//   - Illegal state encoding -> IDLE, outputs 0.
//   - Asserting rst_n mid-operation aborts silently: no event pulse for the aborted gesture.
//   - key_held is registered from next state, so it rises in the cycle after press_down.
// CONFIGURATION
//   KEY_AUTO_REPEAT_EN defined:
//     - In LONG, cnt counts 0..REPEAT_CYC-1 and wraps.
//     - repeat_pulse fires the cycle after each wrap.
//     - First repeat fires REPEAT_CYC cycles after long_press.
//   KEY_AUTO_REPEAT_EN undefined:
//     - repeat_pulse tied to 0.
//     - cnt held at 0 in LONG; REPEAT_CYC unused.
// TESTING  (LONG_CYC=20, DCLK_CYC=10, REPEAT_CYC=4; T = cycle of first press_down)
//   1. down T, up T+5, idle -> short_press only, at T+16; key_held high T+1..T+5.
//   2. down T, hold -> long_press at T+21; up T+30 -> no further events.
//   3. down T, up T+3, down T+6, up T+9 -> double_click at T+10; no short_press.
//   4. down T, up T+3, down T+13 (cnt==9 in GAP) -> treated as second click:
//      up T+15 -> double_click at T+16.
//   5. down T, hold to T+40 with KEY_AUTO_REPEAT_EN -> long_press T+21,
//      repeat_pulse T+25, T+29, T+33, T+37; without macro -> no repeat_pulse.
//   6. down T, rst_n low T+5..T+7, up T+9 -> all outputs 0 throughout, state IDLE.

Source files
------------

// File: rtl/key_event_classifier.sv
// key_event_classifier
//   Classifies debounced key pulses into short-press, long-press and
//   double-click events. Consumes the one-cycle press_down/press_up pulses
//   from the key debouncer and emits one-cycle event pulses to the UI logic.
//
//   Optional feature macro: KEY_AUTO_REPEAT_EN
//     defined   -> repeat_pulse fires every REPEAT_CYC cycles while in LONG
//     undefined -> repeat_pulse tied to 0, REPEAT_CYC unused
//
// Ports
//   clk           in   clock
//   rst_n         in   asynchronous reset, active-low
//   press_down    in   one-cycle pulse: key pressed
//   press_up      in   one-cycle pulse: key released
//   short_press   out  one-cycle pulse: single short click
//   long_press    out  one-cycle pulse: hold reached LONG_CYC
//   double_click  out  one-cycle pulse: second click within DCLK_CYC gap
//   repeat_pulse  out  one-cycle pulse every REPEAT_CYC in LONG (auto-repeat)
//   key_held      out  level: high while in HELD1, HELD2 or LONG
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | key released, no gesture in progress
// HELD1  | first press held, waiting for release or long-press timeout
// GAP    | first click released, waiting for a second press
// HELD2  | second press held, waiting for release or long-press timeout
// LONG   | long press recognised, waiting for release
module key_event_classifier #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DCLK_CYC   = 12_500_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_down,
  input  logic press_up,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic key_held
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HELD1 = 3'd1,
    GAP   = 3'd2,
    HELD2 = 3'd3,
    LONG  = 3'd4
  } state_t;

  // Counter must be able to reach every terminal count.
  if (((64'd1 << CNT_W) <= 64'(LONG_CYC)) ||
      ((64'd1 << CNT_W) <= 64'(DCLK_CYC)) ||
      ((64'd1 << CNT_W) <= 64'(REPEAT_CYC))) begin : g_cnt_w_check
    $error("key_event_classifier: CNT_W too small for configured cycle counts");
  end

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DCLK_TC = CNT_W'(DCLK_CYC - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYC - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, dbl_nxt;
`ifdef KEY_AUTO_REPEAT_EN
  logic             rep_nxt;
`endif

  // A release in the same cycle as a press wins; the press is dropped.
  logic down_eff;
  assign down_eff = press_down & ~press_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dbl_nxt;
      key_held     <= (state_nxt == HELD1) || (state_nxt == HELD2) ||
                      (state_nxt == LONG);
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_pulse <= 1'b0;
    else        repeat_pulse <= rep_nxt;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rep_nxt   = 1'b0;
`endif
    // Input pulses are tested before the timeout so they win in the TC cycle.
    case (state)
      IDLE: begin
        if (down_eff) state_nxt = HELD1;
      end
      HELD1: begin
        if (press_up) begin
          state_nxt = GAP;
        end else if (cnt == LONG_TC) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (down_eff) begin
          state_nxt = HELD2;
        end else if (cnt == DCLK_TC) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      HELD2: begin
        if (press_up) begin
          state_nxt = IDLE;
          dbl_nxt   = 1'b1;
        end else if (cnt == LONG_TC) begin
          // The first click was already complete, so it is reported as well.
          state_nxt = LONG;
          short_nxt = 1'b1;
          long_nxt  = 1'b1;
        end
      end
      LONG: begin
        if (press_up) begin
          state_nxt = IDLE;
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          if (cnt == REPEAT_TC) begin
            cnt_nxt = '0;
            rep_nxt = 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule

// File: tb/tb_key_event_classifier.sv
module tb_key_event_classifier;
  localparam int LONG_CYC   = 20;
  localparam int DCLK_CYC   = 10;
  localparam int REPEAT_CYC = 4;
  localparam int CNT_W      = 8;

  localparam logic [3:0] EV_SHORT = 4'b1000;
  localparam logic [3:0] EV_LONG  = 4'b0100;
  localparam logic [3:0] EV_DBL   = 4'b0010;
  localparam logic [3:0] EV_REP   = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic press_down = 1'b0;
  logic press_up = 1'b0;
  logic short_press, long_press, double_click, repeat_pulse, key_held;

  key_event_classifier #(
    .LONG_CYC  (LONG_CYC),
    .DCLK_CYC  (DCLK_CYC),
    .REPEAT_CYC(REPEAT_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_down  (press_down),
    .press_up    (press_up),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .repeat_pulse(repeat_pulse),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [3:0] ev;} ev_t;
  typedef struct {int c; logic v;} kh_t;
  ev_t ev_q[$];
  kh_t kh_q[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  // Drive a one-cycle input pulse during cycle t.
  task automatic pulse(input int t, input logic d, input logic u);
    run_to(t);
    press_down = d;
    press_up = u;
    step();
    press_down = 1'b0;
    press_up = 1'b0;
  endtask

  task automatic exp_ev(input int c, input logic [3:0] ev);
    ev_t e;
    e.c = c;
    e.ev = ev;
    ev_q.push_back(e);
  endtask

  task automatic exp_kh(input int a, input int b, input logic v);
    kh_t k;
    for (int i = a; i <= b; i++) begin
      k.c = i;
      k.v = v;
      kh_q.push_back(k);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  always @(negedge clk) begin
    logic [3:0] ev;
    kh_t k;
    ev_t e;
    ev = {short_press, long_press, double_click, repeat_pulse};
    while (kh_q.size() > 0 && kh_q[0].c <= cyc) begin
      k = kh_q.pop_front();
      n_checks++;
      if (k.c != cyc || key_held !== k.v) begin
        n_fail++;
        $display("FAIL key_held cyc=%0d got=%b want=%b (for cyc %0d)", cyc, key_held, k.v, k.c);
      end
    end
    if (ev !== 4'b0000) begin
      n_checks++;
      if (ev_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got=%b want=none", cyc, ev);
      end else begin
        e = ev_q.pop_front();
        if (e.c != cyc || e.ev !== ev) begin
          n_fail++;
          $display("FAIL event cyc=%0d got=%b want=%b at cyc %0d", cyc, ev, e.ev, e.c);
        end
      end
    end
  end

  initial begin
    // Reset state
    exp_kh(1, 9, 1'b0);
    run_to(2);
    @(negedge clk);
    n_checks++;
    if ({short_press, long_press, double_click, repeat_pulse, key_held} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=00000",
               {short_press, long_press, double_click, repeat_pulse, key_held});
    end
    run_to(3);
    rst_n = 1'b1;

    // 1: short press
    exp_kh(10, 10, 1'b0);
    exp_kh(11, 15, 1'b1);
    exp_kh(16, 17, 1'b0);
    exp_ev(26, EV_SHORT);
    pulse(10, 1'b1, 1'b0);
    pulse(15, 1'b0, 1'b1);

    // 2: long press, release later
    exp_kh(51, 80, 1'b1);
    exp_kh(81, 81, 1'b0);
    exp_ev(71, EV_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    exp_ev(75, EV_REP);
    exp_ev(79, EV_REP);
`endif
    pulse(50, 1'b1, 1'b0);
    pulse(80, 1'b0, 1'b1);

    // 3: double click
    exp_kh(111, 113, 1'b1);
    exp_kh(114, 116, 1'b0);
    exp_kh(117, 119, 1'b1);
    exp_kh(120, 120, 1'b0);
    exp_ev(120, EV_DBL);
    pulse(110, 1'b1, 1'b0);
    pulse(113, 1'b0, 1'b1);
    pulse(116, 1'b1, 1'b0);
    pulse(119, 1'b0, 1'b1);

    // 4: second press exactly in the gap timeout cycle
    exp_kh(151, 153, 1'b1);
    exp_kh(154, 163, 1'b0);
    exp_kh(164, 165, 1'b1);
    exp_kh(166, 166, 1'b0);
    exp_ev(166, EV_DBL);
    pulse(150, 1'b1, 1'b0);
    pulse(153, 1'b0, 1'b1);
    pulse(163, 1'b1, 1'b0);
    pulse(165, 1'b0, 1'b1);

    // 5: long hold with auto-repeat window
    exp_kh(201, 239, 1'b1);
    exp_kh(240, 240, 1'b0);
    exp_ev(221, EV_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    exp_ev(225, EV_REP);
    exp_ev(229, EV_REP);
    exp_ev(233, EV_REP);
    exp_ev(237, EV_REP);
`endif
    pulse(200, 1'b1, 1'b0);
    pulse(239, 1'b0, 1'b1);

    // 6: reset mid-gesture aborts silently, then a fresh gesture from IDLE
    exp_kh(281, 284, 1'b1);
    exp_kh(285, 292, 1'b0);
    exp_kh(301, 302, 1'b1);
    exp_kh(303, 303, 1'b0);
    exp_ev(313, EV_SHORT);
    pulse(280, 1'b1, 1'b0);
    run_to(285);
    rst_n = 1'b0;
    run_to(288);
    rst_n = 1'b1;
    pulse(289, 1'b0, 1'b1);
    pulse(300, 1'b1, 1'b0);
    pulse(302, 1'b0, 1'b1);

    // 7: simultaneous pulses, stray pulses
    exp_kh(331, 333, 1'b1);
    exp_kh(334, 334, 1'b0);
    exp_ev(344, EV_SHORT);
    exp_kh(361, 362, 1'b0);
    exp_kh(366, 366, 1'b0);
    exp_kh(381, 405, 1'b1);
    exp_kh(406, 406, 1'b0);
    exp_ev(401, EV_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    exp_ev(405, EV_REP);
`endif
    pulse(330, 1'b1, 1'b0);
    pulse(333, 1'b1, 1'b1);
    pulse(360, 1'b1, 1'b1);
    pulse(365, 1'b0, 1'b1);
    pulse(380, 1'b1, 1'b0);
    pulse(382, 1'b1, 1'b0);
    pulse(405, 1'b0, 1'b1);

    // 8: second press held to long -> short and long together
    exp_kh(421, 422, 1'b1);
    exp_kh(423, 425, 1'b0);
    exp_kh(426, 450, 1'b1);
    exp_kh(451, 451, 1'b0);
    exp_ev(446, EV_SHORT | EV_LONG);
`ifdef KEY_AUTO_REPEAT_EN
    exp_ev(450, EV_REP);
`endif
    pulse(420, 1'b1, 1'b0);
    pulse(422, 1'b0, 1'b1);
    pulse(425, 1'b1, 1'b0);
    pulse(450, 1'b0, 1'b1);

    run_to(480);
    step();
    while (ev_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_event got=none want=%b at cyc %0d", ev_q[0].ev, ev_q[0].c);
      void'(ev_q.pop_front());
    end
    while (kh_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL key_held_unchecked got=none want=%b at cyc %0d", kh_q[0].v, kh_q[0].c);
      void'(kh_q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
